regfile_wb_arbiter: RTL and testbench

Sequences the single write port of the 32x32 CPU register file (2 read ports, 1 write port). After reset it clears r1..r31 to a known value. It then shares the write port between two writeback requesters: requester 0 is the ALU writeback and requester 1 is the load/memory writeback. Each requester uses a valid/ready handshake, and the block drives registered write signals into the register file.

---
 rtl/regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the single write port of the 32x32 CPU register file.
//   - After reset it can sweep r1..r31 with CLEAR_VALUE, one register per
//     cycle, so that software never reads an undefined register.
//   - It then shares the write port between two writeback requesters:
//     requester 0 = ALU writeback, requester 1 = load/memory writeback.
//   - All register-file write signals leave this block from flops.
//
// Handshake (both requesters):
//   - A transfer happens on a rising clock edge where valid && ready are
//     both high.
//   - ready is combinational and may depend on valid.
//   - At most one ready is high in any cycle.
//   - A requester that sees valid && !ready must hold addr/data stable and
//     keep valid high.
//   - There is no buffering inside: the loser of a tie simply stalls.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   req0_*      ALU writeback request (valid/addr/data in, ready out)
//   req1_*      load writeback request (valid/addr/data in, ready out)
//   rf_we       register file write enable (registered)
//   rf_wa       register file write address (registered)
//   rf_wd       register file write data (registered)
//   init_busy   high while the clear sequence runs (registered)
//   dbg_state   current FSM state: 0 = INIT, 1 = RUN
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter bit          INIT_CLEAR  = 1'b1,
    parameter logic [31:0] CLEAR_VALUE = 32'd0,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,

    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        init_busy,
    output logic        dbg_state
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q,     state_d;
    logic [4:0]  init_ptr_q,  init_ptr_d;
    logic        rf_we_q,     rf_we_d;
    logic [4:0]  rf_wa_q,     rf_wa_d;
    logic [31:0] rf_wd_q,     rf_wd_d;
    logic        init_busy_q, init_busy_d;
    // Index of the requester granted most recently.
    // The round-robin tie break favours the other one.
    logic        rr_last_q,   rr_last_d;

    logic        grant0;
    logic        grant1;
    logic        accept0;
    logic        accept1;

    // ------------------------------------------------------------------
    // Grant: a lone requester always wins.
    // On a tie, either requester 1 wins outright (FIXED_PRIO) or the
    // requester that did not win last time wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO) begin
                grant1 = 1'b1;
            end else if (rr_last_q) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state_q == ST_RUN) && grant0;
    assign req1_ready = (state_q == ST_RUN) && grant1;

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;

    // ------------------------------------------------------------------
    // Next-state and write-port logic.
    // rf_wa/rf_wd hold their values on idle cycles.
    // rf_we drops back to 0 unless a write is launched this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        rf_we_d     = 1'b0;
        rf_wa_d     = rf_wa_q;
        rf_wd_d     = rf_wd_q;
        init_busy_d = init_busy_q;
        rr_last_d   = rr_last_q;

        case (state_q)
            ST_INIT: begin
                rf_we_d    = 1'b1;
                rf_wa_d    = init_ptr_q;
                rf_wd_d    = CLEAR_VALUE;
                init_ptr_d = init_ptr_q + 5'd1;
                // r31 is the last register cleared.
                // Leave INIT on the same edge that issues its write.
                if (init_ptr_q == 5'd31) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                end
            end

            ST_RUN: begin
                if (accept1) begin
                    rf_wa_d   = req1_addr;
                    rf_wd_d   = req1_data;
                    // A write to r0 still completes its handshake.
                    // It is discarded here by never raising rf_we.
                    rf_we_d   = (req1_addr != 5'd0);
                    rr_last_d = 1'b1;
                end else if (accept0) begin
                    rf_wa_d   = req0_addr;
                    rf_wd_d   = req0_data;
                    rf_we_d   = (req0_addr != 5'd0);
                    rr_last_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // Reset wins over any handshake that lands on the same edge, so such
    // a transfer is lost and produces no write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_CLEAR ? ST_INIT : ST_RUN;
            init_ptr_q  <= 5'd1;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= 5'd0;
            rf_wd_q     <= 32'd0;
            init_busy_q <= INIT_CLEAR;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_wa_q     <= rf_wa_d;
            rf_wd_q     <= rf_wd_d;
            init_busy_q <= init_busy_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;
    assign init_busy = init_busy_q;
    assign dbg_state = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Two instances are exercised:
//   u_rr  : INIT_CLEAR=1, CLEAR_VALUE=DEADBEEF, round-robin arbitration
//   u_fix : INIT_CLEAR=0, FIXED_PRIO=1
//
// Timing:
//   Inputs change 1 ns after a rising edge.
//   Combinational readies are sampled 1 ns after that.
//   Registered outputs are sampled 1 ns after the next rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        r0, r1, we, busy, dbg;
  logic [4:0]  wa;
  logic [31:0] wd;

  logic        rst_b;
  logic        bv0, bv1;
  logic [4:0]  ba0, ba1;
  logic [31:0] bd0, bd1;
  logic        br0, br1, bwe, bbusy, bdbg;
  logic [4:0]  bwa;
  logic [31:0] bwd;

  localparam logic [31:0] CLR = 32'hDEAD_BEEF;

  regfile_wb_arbiter #(.INIT_CLEAR(1'b1), .CLEAR_VALUE(CLR), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .rf_we(we), .rf_wa(wa), .rf_wd(wd), .init_busy(busy), .dbg_state(dbg)
  );

  regfile_wb_arbiter #(.INIT_CLEAR(1'b0), .CLEAR_VALUE(32'd0), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst(rst_b),
    .req0_valid(bv0), .req0_addr(ba0), .req0_data(bd0), .req0_ready(br0),
    .req1_valid(bv1), .req1_addr(ba1), .req1_data(bd1), .req1_ready(br1),
    .rf_we(bwe), .rf_wa(bwa), .rf_wd(bwd), .init_busy(bbusy), .dbg_state(bdbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [37:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule.
  // Returns -1 (nobody), 0 or 1, given the valids and the last winner.
  function automatic int ref_grant(input logic rv0, input logic rv1, input int last, input bit fixed);
    if (rv0 && rv1) return fixed ? 1 : (last == 0 ? 1 : 0);
    if (rv0) return 0;
    if (rv1) return 1;
    return -1;
  endfunction

  // ---------------- table of directed vectors ----------------
  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[11];

  // ---------------- driver tasks ----------------
  task automatic drive_rr(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                          input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
  endtask

  // Checks the 31-cycle clear sweep.
  // Both requesters stay valid throughout, to show that neither is ever
  // made ready while INIT runs.
  task automatic check_init();
    drive_rr(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h1010);
    for (int i = 1; i <= 31; i++) begin
      #1;
      chk($sformatf("init_ready0[%0d]", i), r0, 1'b0);
      chk($sformatf("init_ready1[%0d]", i), r1, 1'b0);
      tick();
      chk($sformatf("init_we[%0d]", i), we, 1'b1);
      chk($sformatf("init_wa[%0d]", i), wa, i[4:0]);
      chk($sformatf("init_wd[%0d]", i), wd, CLR);
      chk($sformatf("init_busy[%0d]", i), busy, (i != 31));
    end
    drive_rr(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("run_state", dbg, 1'b1);
  endtask

  // ---------------- main test ----------------
  initial begin
    int          m_last;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        hold0, hold1;
    logic [37:0] e;
    int          g;
    logic [4:0]  ea;
    logic [31:0] ed;

    tbl[0]  = '{1'b1, 5'd1, 32'hA0,   1'b1, 5'd2, 32'hB0,     1'b1, 1'b0, 1'b1, 5'd1, 32'hA0};
    tbl[1]  = '{1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB0,     1'b0, 1'b1, 1'b1, 5'd2, 32'hB0};
    tbl[2]  = '{1'b1, 5'd1, 32'hA1,   1'b1, 5'd2, 32'hB1,     1'b1, 1'b0, 1'b1, 5'd1, 32'hA1};
    tbl[3]  = '{1'b1, 5'd1, 32'hA2,   1'b1, 5'd2, 32'hB1,     1'b0, 1'b1, 1'b1, 5'd2, 32'hB1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0, 5'd2, 32'hB1};
    tbl[5]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 1'b1, 5'd5, 32'h1234};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0, 5'd5, 32'h1234};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hFFFF,   1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF};
    tbl[8]  = '{1'b1, 5'd3, 32'h33,   1'b1, 5'd4, 32'h44,     1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    tbl[9]  = '{1'b1, 5'd6, 32'h66,   1'b1, 5'd4, 32'h44,     1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    tbl[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0, 5'd4, 32'h44};

    rst = 1'b1; rst_b = 1'b1;
    drive_rr(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bv0 = 1'b0; ba0 = 5'd0; bd0 = 32'd0;
    bv1 = 1'b0; ba1 = 5'd0; bd1 = 32'd0;
    tick();
    tick();

    // ---- u_fix: no clear sweep; fixed priority ----
    rst_b = 1'b0;
    chk("fix_rst_we", bwe, 1'b0);
    chk("fix_rst_wa", bwa, 5'd0);
    chk("fix_rst_wd", bwd, 32'd0);
    chk("fix_rst_busy", bbusy, 1'b0);
    bv0 = 1'b1; ba0 = 5'd8; bd0 = 32'h88;
    #1;
    chk("fix_first_ready0", br0, 1'b1);
    chk("fix_first_ready1", br1, 1'b0);
    tick();
    chk("fix_first_we", bwe, 1'b1);
    chk("fix_first_wa", bwa, 5'd8);
    chk("fix_first_wd", bwd, 32'h88);
    chk("fix_first_busy", bbusy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bv0 = 1'b1; ba0 = 5'd1; bd0 = 32'hA;
      bv1 = 1'b1; ba1 = 5'd2; bd1 = 32'hB0 + k;
      #1;
      chk($sformatf("fix_tie_ready0[%0d]", k), br0, 1'b0);
      chk($sformatf("fix_tie_ready1[%0d]", k), br1, 1'b1);
      tick();
      chk($sformatf("fix_tie_we[%0d]", k), bwe, 1'b1);
      chk($sformatf("fix_tie_wa[%0d]", k), bwa, 5'd2);
      chk($sformatf("fix_tie_wd[%0d]", k), bwd, 32'hB0 + k);
    end
    bv0 = 1'b0; bv1 = 1'b0;
    tick();
    chk("fix_idle_we", bwe, 1'b0);

    // ---- u_rr: reset state, then the clear sweep ----
    rst = 1'b0;
    chk("rst_we", we, 1'b0);
    chk("rst_wa", wa, 5'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_state", dbg, 1'b0);
    check_init();

    // ---- u_rr: table-driven RUN vectors ----
    foreach (tbl[i]) begin
      drive_rr(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("tbl_ready0[%0d]", i), r0, tbl[i].r0);
      chk($sformatf("tbl_ready1[%0d]", i), r1, tbl[i].r1);
      tick();
      chk($sformatf("tbl_we[%0d]", i), we, tbl[i].we);
      chk($sformatf("tbl_wa[%0d]", i), wa, tbl[i].wa);
      chk($sformatf("tbl_wd[%0d]", i), wd, tbl[i].wd);
    end

    // ---- u_rr: reset lands on a req0 handshake to r7 ----
    drive_rr(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready0", r0, 1'b1);
    tick();
    rst = 1'b0;
    drive_rr(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("mid_rst_we", we, 1'b0);
    chk("mid_rst_wa", wa, 5'd0);
    chk("mid_rst_busy", busy, 1'b1);
    check_init();

    // ---- u_rr: randomized traffic against the reference model ----
    m_last = 1;
    m_wa   = 5'd31;
    m_wd   = CLR;
    hold0  = 1'b0;
    hold1  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // A stalled requester keeps its request unchanged.
      if (!hold0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = 5'($urandom_range(0, 31));
        d0 = $urandom;
      end
      if (!hold1) begin
        v1 = ($urandom_range(0, 3) != 0);
        a1 = 5'($urandom_range(0, 31));
        d1 = $urandom;
      end
      #1;
      g = ref_grant(v0, v1, m_last, 1'b0);
      chk("rnd_ready0", r0, (g == 0));
      chk("rnd_ready1", r1, (g == 1));
      if (g >= 0) begin
        ea = (g == 1) ? a1 : a0;
        ed = (g == 1) ? d1 : d0;
        exp_q.push_back({(ea != 5'd0), ea, ed});
        m_last = g;
        m_wa   = ea;
        m_wd   = ed;
      end else begin
        exp_q.push_back({1'b0, m_wa, m_wd});
      end
      hold0 = v0 && (g != 0);
      hold1 = v1 && (g != 1);
      tick();
      e = exp_q.pop_front();
      chk("rnd_we", we, e[37]);
      chk("rnd_wa", wa, e[36:32]);
      chk("rnd_wd", wd, e[31:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
